// File: rtl/touch_report_decoder.sv
// rtl/touch_report_decoder.sv - MTL touch-report frame parser feeding touch_control
// Optional B10 XOR checksum check enabled by defining TOUCH_CHECKSUM_EN.
module touch_report_decoder #(
  parameter logic [9:0]           H_MAX           = 10'd799,
  parameter logic [8:0]           V_MAX           = 9'd479,
  parameter int                   TIMEOUT_W       = 22,
  parameter logic [TIMEOUT_W-1:0] RELEASE_TIMEOUT = 22'd2500000
) (
  input  logic       iCLK,
  input  logic       iRSTN,
  input  logic       iFRAME_START,
  input  logic       iBYTE_VALID,
  input  logic [7:0] iBYTE,
  input  logic       iFRAME_END,
  output logic       oREADY,
  output logic [9:0] oREG_X1,
  output logic [8:0] oREG_Y1,
  output logic [9:0] oREG_X2,
  output logic [8:0] oREG_Y2,
  output logic [1:0] oREG_TOUCH_COUNT,
  output logic [7:0] oREG_GESTURE,
  output logic       oFRAME_ERR
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;
`ifdef TOUCH_CHECKSUM_EN
  localparam logic [3:0] FRAME_BYTES = 4'd11;
`else
  localparam logic [3:0] FRAME_BYTES = 4'd10;
`endif

  logic [1:0]           r_state;
  logic [3:0]           r_idx;
  logic                 r_err;
  logic [7:0]           r_gest_s;
  logic [3:0]           r_cnt_s;
  logic [9:0]           r_x1_s, r_x2_s;
  logic [8:0]           r_y1_s, r_y2_s;
  logic                 r_ready;
  logic [9:0]           r_x1, r_x2;
  logic [8:0]           r_y1, r_y2;
  logic [1:0]           r_cnt;
  logic [7:0]           r_gest;
  logic [TIMEOUT_W-1:0] r_to;

  logic       w_take;
  logic [3:0] w_wr_idx;
  logic [3:0] w_len;
  logic       w_cs_ok;
  logic       w_frame_ok;
  logic [1:0] w_cnt;
  logic [9:0] w_x1, w_x2;
  logic [8:0] w_y1, w_y2;

  // A start pulse always claims its coincident byte as B0, even mid-frame.
  assign w_take   = iBYTE_VALID &&
                    (iFRAME_START || (r_state == S_COLLECT && r_idx < FRAME_BYTES));
  assign w_wr_idx = iFRAME_START ? 4'd0 : r_idx;
  assign w_len    = r_idx + {3'd0, w_take};

`ifdef TOUCH_CHECKSUM_EN
  logic [7:0] r_xor;
  logic [7:0] r_b10;
  logic [7:0] w_b10;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_xor <= 8'h00;
      r_b10 <= 8'h00;
    end else begin
      if (iFRAME_START)
        r_xor <= w_take ? iBYTE : 8'h00;
      else if (w_take && r_idx < 4'd10)
        r_xor <= r_xor ^ iBYTE;
      if (w_take && w_wr_idx == 4'd10)
        r_b10 <= iBYTE;
    end
  end

  assign w_b10   = (w_take && r_idx == 4'd10) ? iBYTE : r_b10;
  assign w_cs_ok = (w_b10 == r_xor);
`else
  assign w_cs_ok = 1'b1;
`endif

  assign w_frame_ok = (w_len >= FRAME_BYTES) && w_cs_ok;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (iFRAME_START) begin
        r_state <= S_COLLECT;
        r_idx   <= {3'd0, w_take};
        r_err   <= (r_state == S_COLLECT);
      end else if (r_state == S_COLLECT) begin
        r_idx <= w_len;
        if (iFRAME_END) begin
          r_state <= w_frame_ok ? S_COMMIT : S_IDLE;
          r_err   <= !w_frame_ok;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  // Shadow fields keep only the bits that survive the width rules.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_gest_s <= 8'h00;
      r_cnt_s  <= 4'd0;
      r_x1_s   <= 10'd0;
      r_y1_s   <= 9'd0;
      r_x2_s   <= 10'd0;
      r_y2_s   <= 9'd0;
    end else if (w_take) begin
      case (w_wr_idx)
        4'd0:    r_gest_s      <= iBYTE;
        4'd1:    r_cnt_s       <= iBYTE[3:0];
        4'd2:    r_x1_s[9:8]   <= iBYTE[1:0];
        4'd3:    r_x1_s[7:0]   <= iBYTE;
        4'd4:    r_y1_s[8]     <= iBYTE[0];
        4'd5:    r_y1_s[7:0]   <= iBYTE;
        4'd6:    r_x2_s[9:8]   <= iBYTE[1:0];
        4'd7:    r_x2_s[7:0]   <= iBYTE;
        4'd8:    r_y2_s[8]     <= iBYTE[0];
        4'd9:    r_y2_s[7:0]   <= iBYTE;
        default: ;
      endcase
    end
  end

  assign w_cnt = (r_cnt_s > 4'd2) ? 2'd2 : r_cnt_s[1:0];
  assign w_x1  = (r_x1_s > H_MAX) ? H_MAX : r_x1_s;
  assign w_y1  = (r_y1_s > V_MAX) ? V_MAX : r_y1_s;
  assign w_x2  = (r_x2_s > H_MAX) ? H_MAX : r_x2_s;
  assign w_y2  = (r_y2_s > V_MAX) ? V_MAX : r_y2_s;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_to <= '0;
    end else if (r_state == S_COMMIT) begin
      r_to <= '0;
    end else if (r_to != {TIMEOUT_W{1'b1}}) begin
      r_to <= r_to + 1'b1;
    end
  end

  // Commit wins over release; coordinates are never cleared by release.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_ready <= 1'b0;
      r_x1    <= 10'd0;
      r_y1    <= 9'd0;
      r_x2    <= 10'd0;
      r_y2    <= 9'd0;
      r_cnt   <= 2'd0;
      r_gest  <= 8'h00;
    end else if (r_state == S_COMMIT) begin
      r_gest  <= r_gest_s;
      r_cnt   <= w_cnt;
      r_ready <= (w_cnt != 2'd0);
      if (w_cnt != 2'd0) begin
        r_x1 <= w_x1;
        r_y1 <= w_y1;
      end
      if (w_cnt == 2'd2) begin
        r_x2 <= w_x2;
        r_y2 <= w_y2;
      end
    end else if (r_ready && r_to >= RELEASE_TIMEOUT) begin
      r_ready <= 1'b0;
      r_gest  <= 8'h00;
      r_cnt   <= 2'd0;
    end
  end

  assign oREADY           = r_ready;
  assign oREG_X1          = r_x1;
  assign oREG_Y1          = r_y1;
  assign oREG_X2          = r_x2;
  assign oREG_Y2          = r_y2;
  assign oREG_TOUCH_COUNT = r_cnt;
  assign oREG_GESTURE     = r_gest;
  assign oFRAME_ERR       = r_err;

endmodule

// File: tb/tb_touch_report_decoder.sv
// tb/tb_touch_report_decoder.sv - scoreboard bench for touch_report_decoder
// Define TOUCH_CHECKSUM_EN to exercise the checksum build.
`timescale 1ns/1ps
module tb_touch_report_decoder;
  localparam logic [21:0] RT = 22'd200;
`ifdef TOUCH_CHECKSUM_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       iCLK = 1'b0;
  logic       iRSTN = 1'b1;
  logic       iFRAME_START = 1'b0;
  logic       iBYTE_VALID = 1'b0;
  logic [7:0] iBYTE = 8'h00;
  logic       iFRAME_END = 1'b0;
  logic       oREADY;
  logic [9:0] oREG_X1, oREG_X2;
  logic [8:0] oREG_Y1, oREG_Y2;
  logic [1:0] oREG_TOUCH_COUNT;
  logic [7:0] oREG_GESTURE;
  logic       oFRAME_ERR;

  touch_report_decoder #(.RELEASE_TIMEOUT(RT)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iFRAME_START(iFRAME_START),
    .iBYTE_VALID(iBYTE_VALID), .iBYTE(iBYTE), .iFRAME_END(iFRAME_END),
    .oREADY(oREADY), .oREG_X1(oREG_X1), .oREG_Y1(oREG_Y1),
    .oREG_X2(oREG_X2), .oREG_Y2(oREG_Y2), .oREG_TOUCH_COUNT(oREG_TOUCH_COUNT),
    .oREG_GESTURE(oREG_GESTURE), .oFRAME_ERR(oFRAME_ERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          cyc;
    logic [49:0] v;
  } ev_t;

  ev_t         q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [7:0]  fb [0:15];
  logic [48:0] prev_o = '0;
  logic [49:0] m_cur;
  ev_t         m_e;

  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic logic [49:0] pk(input logic err, input logic rdy,
                                     input logic [9:0] x1, input logic [8:0] y1,
                                     input logic [9:0] x2, input logic [8:0] y2,
                                     input logic [1:0] c, input logic [7:0] g);
    return {err, rdy, x1, y1, x2, y2, c, g};
  endfunction

  task automatic push(input int c, input logic [49:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endtask

  // Event = error pulse or any change of the registered outputs.
  always @(negedge iCLK) begin
    m_cur = pk(oFRAME_ERR, oREADY, oREG_X1, oREG_Y1, oREG_X2, oREG_Y2,
               oREG_TOUCH_COUNT, oREG_GESTURE);
    if (oFRAME_ERR || m_cur[48:0] != prev_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d actual=%h required=none", cyc, m_cur);
      end else begin
        m_e = q.pop_front();
        if (m_cur !== m_e.v) begin
          errors++;
          $display("FAIL event_value cyc=%0d actual=%h required=%h", cyc, m_cur, m_e.v);
        end
        if (m_e.cyc >= 0) begin
          checks++;
          if (cyc != m_e.cyc) begin
            errors++;
            $display("FAIL event_cycle actual=%0d required=%0d", cyc, m_e.cyc);
          end
        end
      end
    end
    prev_o = m_cur[48:0];
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [95:0] v);
    for (int i = 0; i < 12; i++) fb[i] = v[95-8*i -: 8];
  endtask

  task automatic add_cs();
`ifdef TOUCH_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 10; i++) x = x ^ fb[i];
    fb[10] = x;
`endif
  endtask

  task automatic send(input int n, input bit merge_start, input bit merge_end,
                      input bit do_end, output int start_cyc, output int end_cyc);
    int i0;
    i0 = 0;
    end_cyc = -1;
    start_cyc = cyc;
    iFRAME_START = 1'b1;
    if (merge_start) begin
      iBYTE_VALID = 1'b1;
      iBYTE = fb[0];
      i0 = 1;
    end
    tick();
    iFRAME_START = 1'b0;
    iBYTE_VALID = 1'b0;
    for (int i = i0; i < n; i++) begin
      iBYTE_VALID = 1'b1;
      iBYTE = fb[i];
      if (do_end && merge_end && i == n - 1) begin
        iFRAME_END = 1'b1;
        end_cyc = cyc;
      end
      tick();
    end
    iBYTE_VALID = 1'b0;
    iFRAME_END = 1'b0;
    if (do_end && end_cyc < 0) begin
      iFRAME_END = 1'b1;
      end_cyc = cyc;
      tick();
      iFRAME_END = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int sc, ec, c0;
    #2 iRSTN = 1'b0;
    idle(3);
    checks++;
    if (pk(oFRAME_ERR, oREADY, oREG_X1, oREG_Y1, oREG_X2, oREG_Y2,
           oREG_TOUCH_COUNT, oREG_GESTURE) !== 50'd0) begin
      errors++;
      $display("FAIL reset_state actual=%b%b required=0", oREADY, oREG_GESTURE);
    end
    iRSTN = 1'b1;
    idle(2);

    // Stray bytes and frame end while idle: no effect.
    iBYTE_VALID = 1'b1; iBYTE = 8'h55; tick();
    iFRAME_END = 1'b1; tick();
    iBYTE_VALID = 1'b0; iFRAME_END = 1'b0; idle(2);

    // Two-point frame.
    load(96'h48_02_01_2C_00_F0_02_58_01_0E_00_00); add_cs();
    send(NB, 0, 0, 1, sc, ec);
    push(ec + 2, pk(1'b0, 1'b1, 10'd300, 9'd240, 10'd600, 9'd270, 2'd1 + 2'd1, 8'h48));
    idle(3);

    // Clamped single point; X2/Y2 hold.
    load(96'h00_01_03_FF_01_FF_00_05_00_06_00_00); add_cs();
    send(NB, 0, 0, 1, sc, ec);
    push(ec + 2, pk(1'b0, 1'b1, 10'd799, 9'd479, 10'd600, 9'd270, 2'd1, 8'h00));
    idle(3);

    // Short frame of 6 bytes.
    load(96'h11_22_33_44_55_66_00_00_00_00_00_00);
    send(6, 0, 0, 1, sc, ec);
    push(ec + 1, pk(1'b1, 1'b1, 10'd799, 9'd479, 10'd600, 9'd270, 2'd1, 8'h00));
    idle(3);

    // One byte short, end coincident with last byte.
    load(96'h48_02_01_2C_00_F0_02_58_01_0E_00_00); add_cs();
    send(NB - 1, 0, 1, 1, sc, ec);
    push(ec + 1, pk(1'b1, 1'b1, 10'd799, 9'd479, 10'd600, 9'd270, 2'd1, 8'h00));
    idle(3);

    // Count 7 saturates to 2, masked MSB bits, then forced release.
    load(96'h14_07_00_0A_01_00_FC_FF_FE_10_00_00); add_cs();
    send(NB, 0, 1, 1, sc, ec);
    c0 = ec + 2;
    push(c0, pk(1'b0, 1'b1, 10'd10, 9'd256, 10'd255, 9'd16, 2'd2, 8'h14));
    push(c0 + int'(RT) + 1, pk(1'b0, 1'b0, 10'd10, 9'd256, 10'd255, 9'd16, 2'd0, 8'h00));
    while (cyc < c0 + int'(RT) + 10) tick();

    // Touch, then count-0 frame drops oREADY and keeps coordinates.
    load(96'h4A_01_00_64_00_32_00_00_00_00_00_00); add_cs();
    send(NB, 0, 0, 1, sc, ec);
    push(ec + 2, pk(1'b0, 1'b1, 10'd100, 9'd50, 10'd255, 9'd16, 2'd1, 8'h4A));
    idle(3);
    load(96'h4F_10_03_FF_01_FF_03_FF_01_FF_00_00); add_cs();
    send(NB, 0, 0, 1, sc, ec);
    push(ec + 2, pk(1'b0, 1'b0, 10'd100, 9'd50, 10'd255, 9'd16, 2'd0, 8'h4F));
    idle(3);

    // Restart after 4 bytes, then full frame with merged start/end.
    load(96'h01_02_03_04_00_00_00_00_00_00_00_00);
    send(4, 0, 0, 0, sc, ec);
    load(96'h1C_01_03_00_01_00_00_00_00_00_00_00); add_cs();
    push(cyc + 1, pk(1'b1, 1'b0, 10'd100, 9'd50, 10'd255, 9'd16, 2'd0, 8'h4F));
    send(NB, 1, 1, 1, sc, ec);
    push(ec + 2, pk(1'b0, 1'b1, 10'd768, 9'd256, 10'd255, 9'd16, 2'd1, 8'h1C));
    idle(3);

    // Extra trailing bytes are ignored.
    load(96'h14_02_00_01_00_02_00_03_00_04_AA_BB); add_cs();
    send(12, 0, 0, 1, sc, ec);
    push(ec + 2, pk(1'b0, 1'b1, 10'd1, 9'd2, 10'd3, 9'd4, 2'd2, 8'h14));
    idle(3);

`ifdef TOUCH_CHECKSUM_EN
    load(96'h48_02_01_2C_00_F0_02_58_01_0E_00_00); add_cs();
    fb[10] = fb[10] ^ 8'h01;
    send(NB, 0, 0, 1, sc, ec);
    push(ec + 1, pk(1'b1, 1'b1, 10'd1, 9'd2, 10'd3, 9'd4, 2'd2, 8'h14));
    idle(3);
`endif

    // Reset mid-frame, then orphan bytes must not complete a frame.
    load(96'h48_02_01_2C_00_F0_02_58_01_0E_00_00); add_cs();
    send(3, 0, 0, 0, sc, ec);
    push(-1, 50'd0);
    iRSTN = 1'b0;
    idle(2);
    iRSTN = 1'b1;
    idle(1);
    for (int i = 3; i < NB; i++) begin
      iBYTE_VALID = 1'b1; iBYTE = fb[i]; tick();
    end
    iBYTE_VALID = 1'b0; iFRAME_END = 1'b1; tick();
    iFRAME_END = 1'b0; idle(3);

    send(NB, 0, 0, 1, sc, ec);
    push(ec + 2, pk(1'b0, 1'b1, 10'd300, 9'd240, 10'd600, 9'd270, 2'd2, 8'h48));
    idle(10);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
